// File: rtl/packet_assembler_pkg.sv
// Shared NoC defaults and receive-FSM encoding.
// Used by the ejection assembler and port controller.
package packet_assembler_pkg;

  localparam int FLIT_SIZE_D    = 4;
  localparam int PACKET_SIZE_D  = 32;
  localparam int ADDRESS_SIZE_D = 16;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    RECV_ADDR    = 2'd1,
    RECV_PAYLOAD = 2'd2
  } state_t;

endpackage

// File: rtl/packet_assembler_flit_shift_reg.sv
// Flit shift register: first flit shifted in
// ends up in the MSBs after a full packet.
module flit_shift_reg #(
  parameter int FLIT_SIZE   = 4,
  parameter int PACKET_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic [FLIT_SIZE-1:0]   flit_in,
  output logic [PACKET_SIZE-1:0] data_out
);

  localparam int KEEP = PACKET_SIZE - FLIT_SIZE;

  // shift one flit in from the LSB side
  always_ff @(posedge clk) begin
    if (reset)
      data_out <= '0;
    else if (shift_en)
      data_out <= {data_out[KEEP-1:0], flit_in};
  end

endmodule

// File: rtl/packet_assembler.sv
// Ejection-side packet assembler: flit stream in,
// whole packet out through a valid/ready holding register.
module packet_assembler
  import packet_assembler_pkg::*;
#(
  parameter int FLIT_SIZE    = FLIT_SIZE_D,
  parameter int PACKET_SIZE  = PACKET_SIZE_D,
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_D
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [FLIT_SIZE-1:0]    flit_in,
  input  logic                    flit_valid,
  output logic                    stall,
  output logic                    header_valid,
  output logic [ADDRESS_SIZE-1:0] header_addr,
  output logic                    packet_valid,
  input  logic                    packet_ready,
  output logic [PACKET_SIZE-1:0]  packet_out,
  output logic [ADDRESS_SIZE-1:0] address_out,
  output logic [PACKET_SIZE-ADDRESS_SIZE-1:0] payload_out,
  output logic                    proto_err
);

  localparam int ADDR_FLITS = ADDRESS_SIZE / FLIT_SIZE;
  localparam int FLIT_NUM   = PACKET_SIZE / FLIT_SIZE;
  localparam int CNT_W      = $clog2(FLIT_NUM);
  localparam int PAY_SIZE   = PACKET_SIZE - ADDRESS_SIZE;

  localparam logic [CNT_W-1:0] ADDR_LAST =
    CNT_W'(ADDR_FLITS - 1);
  localparam logic [CNT_W-1:0] FLIT_LAST =
    CNT_W'(FLIT_NUM - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [PACKET_SIZE-1:0]   sreg;
  logic [PACKET_SIZE-1:0]   hold;
  logic [ADDRESS_SIZE-1:0]  hdr_nxt;
  logic                     shift_en;
  logic                     drop;
  logic                     hdr_hit;
  logic                     last_hit;
  logic                     load_q;
  logic                     hold_v;

  flit_shift_reg #(
    .FLIT_SIZE   (FLIT_SIZE),
    .PACKET_SIZE (PACKET_SIZE)
  ) u_sreg (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .flit_in  (flit_in),
    .data_out (sreg)
  );

  // address as it will sit in sreg after this shift
  if (ADDRESS_SIZE == FLIT_SIZE) begin : g_hdr_one
    assign hdr_nxt = flit_in;
  end else begin : g_hdr_many
    assign hdr_nxt =
      {sreg[ADDRESS_SIZE-FLIT_SIZE-1:0], flit_in};
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next-state: advance on flit count boundaries
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (flit_valid && !stall)
          state_nxt = (ADDR_FLITS == 1) ?
            RECV_PAYLOAD : RECV_ADDR;
      end
      RECV_ADDR: begin
        if (flit_valid && cnt == ADDR_LAST)
          state_nxt = RECV_PAYLOAD;
      end
      RECV_PAYLOAD: begin
        if (flit_valid && cnt == FLIT_LAST)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: accept/drop decisions per state
  always_comb begin
    shift_en = 1'b0;
    drop     = 1'b0;
    unique case (state)
      IDLE: begin
        shift_en = flit_valid && !stall;
        drop     = flit_valid && stall;
      end
      RECV_ADDR,
      RECV_PAYLOAD: shift_en = flit_valid;
      default: ;
    endcase
    hdr_hit  = shift_en && (cnt == ADDR_LAST);
    last_hit = shift_en && (state == RECV_PAYLOAD) &&
               (cnt == FLIT_LAST);
  end

  // flit counter, cleared when the packet completes
  always_ff @(posedge clk) begin
    if (reset || last_hit)
      cnt <= '0;
    else if (shift_en)
      cnt <= cnt + 1'b1;
  end

  // header capture and protocol error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      header_valid <= 1'b0;
      header_addr  <= '0;
      proto_err    <= 1'b0;
    end else begin
      header_valid <= hdr_hit;
      proto_err    <= drop;
      if (hdr_hit)
        header_addr <= hdr_nxt;
    end
  end

  // copy sreg to holding one cycle after the last flit
  always_ff @(posedge clk) begin
    if (reset) begin
      load_q <= 1'b0;
      hold_v <= 1'b0;
      hold   <= '0;
    end else begin
      load_q <= last_hit;
      if (load_q) begin
        hold   <= sreg;
        hold_v <= 1'b1;
      end else if (hold_v && packet_ready) begin
        hold_v <= 1'b0;
      end
    end
  end

  // copy cycle also stalls so no header races the load
  assign stall        = hold_v | load_q;
  assign packet_valid = hold_v;
  assign packet_out   = hold;
  assign address_out  =
    hold[PACKET_SIZE-1 -: ADDRESS_SIZE];
  assign payload_out  = hold[PAY_SIZE-1:0];

endmodule

// File: tb/tb_packet_assembler.sv
// Bench for packet_assembler: 4/32/16 and 8/64/8
// configurations against a queue-based packet model.
module tb_packet_assembler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] flit;
  logic       fv;
  logic       ready;
  logic       sel;

  logic        a_stall, a_hv, a_pv, a_err;
  logic [15:0] a_haddr, a_addr, a_pay;
  logic [31:0] a_pkt;
  logic        b_stall, b_hv, b_pv, b_err;
  logic [7:0]  b_haddr, b_addr;
  logic [55:0] b_pay;
  logic [63:0] b_pkt;

  logic        m_stall, m_hv, m_pv, m_err;
  logic [63:0] m_haddr, m_addr, m_pay, m_pkt;

  always #5 clk = ~clk;

  packet_assembler #(
    .FLIT_SIZE(4), .PACKET_SIZE(32), .ADDRESS_SIZE(16)
  ) dut_a (
    .clk(clk), .reset(reset),
    .flit_in(flit[3:0]), .flit_valid(fv & ~sel),
    .stall(a_stall), .header_valid(a_hv),
    .header_addr(a_haddr), .packet_valid(a_pv),
    .packet_ready(ready), .packet_out(a_pkt),
    .address_out(a_addr), .payload_out(a_pay),
    .proto_err(a_err)
  );

  packet_assembler #(
    .FLIT_SIZE(8), .PACKET_SIZE(64), .ADDRESS_SIZE(8)
  ) dut_b (
    .clk(clk), .reset(reset),
    .flit_in(flit), .flit_valid(fv & sel),
    .stall(b_stall), .header_valid(b_hv),
    .header_addr(b_haddr), .packet_valid(b_pv),
    .packet_ready(ready), .packet_out(b_pkt),
    .address_out(b_addr), .payload_out(b_pay),
    .proto_err(b_err)
  );

  always_comb begin
    if (sel) begin
      m_stall = b_stall; m_hv = b_hv;
      m_pv = b_pv; m_err = b_err;
      m_haddr = 64'(b_haddr); m_addr = 64'(b_addr);
      m_pay = 64'(b_pay); m_pkt = b_pkt;
    end else begin
      m_stall = a_stall; m_hv = a_hv;
      m_pv = a_pv; m_err = a_err;
      m_haddr = 64'(a_haddr); m_addr = 64'(a_addr);
      m_pay = 64'(a_pay); m_pkt = 64'(a_pkt);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fs, ps, as, fnum, afl;

  logic [63:0] pq[$];
  logic [63:0] hq[$];
  int hv_cnt = 0, hv_cyc = 0, deliv = 0;
  int pv_hi = 0, pv_rise = 0, err_cnt = 0;
  int exp_err = 0;
  logic pv_prev = 1'b0;
  logic [63:0] last_pkt = '0, last_haddr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] msk(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, want event", nm);
  endtask

  task automatic cfg(input logic s);
    sel = s;
    if (s) begin fs = 8; ps = 64; as = 8; end
    else begin fs = 4; ps = 32; as = 16; end
    fnum = ps / fs;
    afl  = as / fs;
  endtask

  // model: every accepted packet must come out whole, in order
  always @(negedge clk) begin
    if (!reset) begin
      if (m_hv) begin
        hv_cnt++;
        hv_cyc = cyc;
        last_haddr = m_haddr;
        if (hq.size() == 0)
          chk("hdr_unexpected", 64'(m_hv), 64'd0);
        else
          chk("header_addr", m_haddr, hq.pop_front());
      end
      if (m_pv) begin
        pv_hi++;
        if (!pv_prev) pv_rise = cyc;
        last_pkt = m_pkt;
        if (pq.size() == 0) begin
          chk("pkt_unexpected", 64'(m_pv), 64'd0);
        end else begin
          chk("packet_out", m_pkt, pq[0]);
          chk("address_out", m_addr,
              (pq[0] >> (ps - as)) & msk(as));
          chk("payload_out", m_pay,
              pq[0] & msk(ps - as));
          if (ready) begin
            void'(pq.pop_front());
            deliv++;
          end
        end
      end
      if (m_err) err_cnt++;
    end
    pv_prev = m_pv & ~reset;
  end

  task automatic wait_nostall();
    int n = 0;
    while (m_stall && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) timeout("stall_release");
  endtask

  task automatic wait_pv();
    int n = 0;
    while (!m_pv && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) timeout("packet_valid");
  endtask

  task automatic drain();
    int n = 0;
    while ((pq.size() != 0 || m_pv) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) timeout("drain");
  endtask

  task automatic send(input logic [63:0] pkt,
                      input int gap, input int nfl,
                      input bit push,
                      output int first, output int last);
    wait_nostall();
    if (push) begin
      pq.push_back(pkt);
      hq.push_back((pkt >> (ps - as)) & msk(as));
    end
    first = cyc;
    last  = cyc;
    for (int i = 0; i < nfl; i++) begin
      flit = 8'((pkt >> (ps - (i + 1) * fs)) & msk(fs));
      fv   = 1'b1;
      last = cyc;
      @(posedge clk); #1;
      fv = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test1(input logic [63:0] p,
                       input logic [63:0] haddr);
    int f, l, h0, d0, v0;
    ready = 1'b1;
    h0 = hv_cnt; d0 = deliv; v0 = pv_hi;
    send(p, 0, fnum, 1'b1, f, l);
    drain();
    chk("t1_pkt_literal", last_pkt, p);
    chk("t1_haddr_literal", last_haddr, haddr);
    chk("t1_hv_once", 64'(hv_cnt - h0), 64'd1);
    chk("t1_delivered", 64'(deliv - d0), 64'd1);
    chk("t1_pv_one_cycle", 64'(pv_hi - v0), 64'd1);
    chk("t1_hdr_latency", 64'(hv_cyc - f), 64'(afl));
    chk("t1_pkt_latency", 64'(pv_rise - l), 64'd2);
  endtask

  task automatic test3(input logic [63:0] pa,
                       input logic [63:0] pb);
    int f, l, e0, d0;
    ready = 1'b0;
    d0 = deliv;
    send(pa, 0, fnum, 1'b1, f, l);
    wait_pv();
    repeat (2) begin @(posedge clk); #1; end
    chk("t3_stall_held", 64'(m_stall), 64'd1);
    e0 = err_cnt;
    flit = 8'hFF;
    fv = 1'b1;
    exp_err++;
    @(posedge clk); #1;
    fv = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("t3_one_err", 64'(err_cnt - e0), 64'd1);
    chk("t3_still_valid", 64'(m_pv), 64'd1);
    chk("t3_pkt_held", m_pkt, pa);
    ready = 1'b1;
    send(pb, 0, fnum, 1'b1, f, l);
    drain();
    chk("t3_delivered", 64'(deliv - d0), 64'd2);
    chk("t3_b_literal", last_pkt, pb);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, l, f2, l2, e0, d0, h0;
    reset = 1'b1; fv = 1'b0; flit = '0; ready = 1'b1;
    cfg(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_stall", 64'(a_stall), 64'd0);
    chk("rst_a_pv", 64'(a_pv), 64'd0);
    chk("rst_a_hv", 64'(a_hv), 64'd0);
    chk("rst_a_err", 64'(a_err), 64'd0);
    chk("rst_a_pkt", 64'(a_pkt), 64'd0);
    chk("rst_b_stall", 64'(b_stall), 64'd0);
    chk("rst_b_pkt", b_pkt, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    test1(64'h12345678, 64'h1234);

    h0 = hv_cnt; d0 = deliv;
    send(64'h12345678, 2, fnum, 1'b1, f, l);
    drain();
    chk("t2_pkt_literal", last_pkt, 64'h12345678);
    chk("t2_hv_once", 64'(hv_cnt - h0), 64'd1);
    chk("t2_pv_once", 64'(deliv - d0), 64'd1);

    test3(64'hCAFE5A5A, 64'h0F1E2D3C);

    e0 = err_cnt;
    send(64'h55556666, 0, 3, 1'b0, f, l);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t4_rst_stall", 64'(m_stall), 64'd0);
    chk("t4_rst_pv", 64'(m_pv), 64'd0);
    chk("t4_rst_haddr", m_haddr, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    send(64'hABCD0123, 0, fnum, 1'b1, f, l);
    drain();
    chk("t4_pkt_literal", last_pkt, 64'hABCD0123);
    chk("t4_no_err", 64'(err_cnt - e0), 64'd0);

    d0 = deliv;
    send(64'h11112222, 0, fnum, 1'b1, f, l);
    send(64'h33334444, 0, fnum, 1'b1, f2, l2);
    drain();
    chk("t5_gap", 64'(f2 - l), 64'd3);
    chk("t5_delivered", 64'(deliv - d0), 64'd2);
    chk("t5_last_literal", last_pkt, 64'h33334444);

    cfg(1'b1);
    @(posedge clk); #1;
    test1(64'hA1B2C3D4E5F60718, 64'hA1);
    test3(64'h5AC3000011112222, 64'h0123456789ABCDEF);

    chk("end_pkt_queue", 64'(pq.size()), 64'd0);
    chk("end_hdr_queue", 64'(hq.size()), 64'd0);
    chk("end_err_total", 64'(err_cnt), 64'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
